// File: rtl/key_filter.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM on the active-low key,
// producing a clean level plus one-cycle press, release and long-press pulses.
module key_filter #(
    parameter int unsigned CNT_MAX  = 999_999,
    parameter int unsigned LONG_MAX = 49_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_state,
    output logic key_flag,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned CW = $clog2(CNT_MAX + 1);
    localparam int unsigned LW = $clog2(LONG_MAX + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        DOWN       = 2'd2,
        REL_FILT   = 2'd3
    } state_t;

    state_t        state_q;
    logic          k1_q;
    logic          k2_q;
    logic [CW-1:0] cnt_q;
    logic [LW-1:0] lcnt_q;
    logic          long_done_q;
    logic          key_state_q;
    logic          key_flag_q;
    logic          key_release_q;
    logic          key_long_q;

    // Pulses default low every cycle; the FSM raises them for exactly one cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            k1_q          <= 1'b1;
            k2_q          <= 1'b1;
            state_q       <= IDLE;
            cnt_q         <= '0;
            lcnt_q        <= '0;
            long_done_q   <= 1'b0;
            key_state_q   <= 1'b1;
            key_flag_q    <= 1'b0;
            key_release_q <= 1'b0;
            key_long_q    <= 1'b0;
        end else begin
            k1_q          <= key_in;
            k2_q          <= k1_q;
            key_flag_q    <= 1'b0;
            key_release_q <= 1'b0;
            key_long_q    <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (!k2_q) begin
                        state_q <= PRESS_FILT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_FILT: begin
                    if (k2_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CW'(CNT_MAX)) begin
                        state_q     <= DOWN;
                        key_flag_q  <= 1'b1;
                        key_state_q <= 1'b0;
                        cnt_q       <= '0;
                        lcnt_q      <= '0;
                        long_done_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DOWN: begin
                    if (k2_q) begin
                        state_q <= REL_FILT;
                        cnt_q   <= '0;
                    end else if (!long_done_q) begin
                        if (lcnt_q == LW'(LONG_MAX)) begin
                            key_long_q  <= 1'b1;
                            long_done_q <= 1'b1;
                        end else begin
                            lcnt_q <= lcnt_q + LW'(1);
                        end
                    end
                end
                REL_FILT: begin
                    // A bounce back to DOWN keeps the long-press progress intact.
                    if (!k2_q) begin
                        state_q <= DOWN;
                        cnt_q   <= '0;
                    end else if (cnt_q == CW'(CNT_MAX)) begin
                        state_q       <= IDLE;
                        key_release_q <= 1'b1;
                        key_state_q   <= 1'b1;
                        cnt_q         <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign key_state   = key_state_q;
    assign key_flag    = key_flag_q;
    assign key_release = key_release_q;
    assign key_long    = key_long_q;

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with CNT_MAX=9, LONG_MAX=20. Cycle index i counts the
// rising edge at which the key_in value driven for that step is first sampled.
module tb_key_filter;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic key_in;
    logic key_state;
    logic key_flag;
    logic key_release;
    logic key_long;

    int checks = 0;
    int errors = 0;

    key_filter #(.CNT_MAX(9), .LONG_MAX(20)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_in     (key_in),
        .key_state  (key_state),
        .key_flag   (key_flag),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        sys_rst = 1'b1;
        key_in  = 1'b1;
        tick();
        tick();
        obs = {key_state, key_flag, key_release, key_long};
        checks++;
        if (obs !== 4'b1000) begin
            errors++;
            $display("FAIL reset got=%b exp=%b", obs, 4'b1000);
        end
        sys_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            obs = {key_state, key_flag, key_release, key_long};
            checks++;
            if (obs !== 4'b1000) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs, 4'b1000);
            end
        end
    endtask

    // Press at 0, release from 28: flag after edge 12, release after edge 40, no long.
    task automatic test_clean_press();
        logic [3:0] obs;
        logic [3:0] exp;
        for (int i = 0; i <= 45; i++) begin
            key_in = (i >= 28);
            tick();
            obs = {key_state, key_flag, key_release, key_long};
            exp = {(i < 12) || (i >= 40), i == 12, i == 40, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL clean_press cyc=%0d got=%b exp=%b", i, obs, exp);
            end
        end
    endtask

    // Low 5, high 1, steady low from 6: only one flag, after edge 18.
    task automatic test_press_bounce();
        logic [3:0] obs;
        logic [3:0] exp;
        for (int i = 0; i <= 45; i++) begin
            key_in = (i == 5) || (i >= 28);
            tick();
            obs = {key_state, key_flag, key_release, key_long};
            exp = {!((i >= 18) && (i < 40)), i == 18, i == 40, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL press_bounce cyc=%0d got=%b exp=%b", i, obs, exp);
            end
        end
    endtask

    // Release glitch at 20..22, low 23..24, steady high from 25: release after edge 37.
    task automatic test_release_bounce();
        logic [3:0] obs;
        logic [3:0] exp;
        for (int i = 0; i <= 42; i++) begin
            key_in = ((i >= 20) && (i <= 22)) || (i >= 25);
            tick();
            obs = {key_state, key_flag, key_release, key_long};
            exp = {!((i >= 12) && (i < 37)), i == 12, i == 37, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL release_bounce cyc=%0d got=%b exp=%b", i, obs, exp);
            end
        end
    endtask

    // Held 60 cycles past confirmation (edge 12): long once after edge 33, release after 84.
    task automatic test_long_press();
        logic [3:0] obs;
        logic [3:0] exp;
        for (int i = 0; i <= 90; i++) begin
            key_in = (i >= 72);
            tick();
            obs = {key_state, key_flag, key_release, key_long};
            exp = {!((i >= 12) && (i < 84)), i == 12, i == 84, i == 33};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL long_press cyc=%0d got=%b exp=%b", i, obs, exp);
            end
        end
    endtask

    // FSM holds DOWN 20 cycles (key_in high from 31) vs 21 cycles (from 32).
    task automatic test_long_boundary();
        logic [3:0] obs;
        logic [3:0] exp;
        for (int i = 0; i <= 48; i++) begin
            key_in = (i >= 31);
            tick();
            obs = {key_state, key_flag, key_release, key_long};
            exp = {!((i >= 12) && (i < 43)), i == 12, i == 43, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL long_bound20 cyc=%0d got=%b exp=%b", i, obs, exp);
            end
        end
        for (int i = 0; i <= 48; i++) begin
            key_in = (i >= 32);
            tick();
            obs = {key_state, key_flag, key_release, key_long};
            exp = {!((i >= 12) && (i < 44)), i == 12, i == 44, i == 33};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL long_bound21 cyc=%0d got=%b exp=%b", i, obs, exp);
            end
        end
    endtask

    // Reset at edges 9,10 (PRESS_FILT, cnt=6); refilter gives one flag after edge 23.
    task automatic test_reset_mid();
        logic [3:0] obs;
        logic [3:0] exp;
        for (int i = 0; i <= 46; i++) begin
            key_in  = (i >= 30);
            sys_rst = (i == 9) || (i == 10);
            tick();
            obs = {key_state, key_flag, key_release, key_long};
            exp = {!((i >= 23) && (i < 42)), i == 23, i == 42, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", i, obs, exp);
            end
        end
        sys_rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_long_press();
        test_long_boundary();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
